// File: rtl/pci_initiator.sv
// PCI-style bus master: one local request becomes an address phase plus up to MAX_BURST data phases.
// A cycle that no target claims within DEVSEL_TIMEOUT data cycles ends in a master abort.
module pci_initiator #(
  parameter int          MAX_BURST      = 8,
  parameter int          DEVSEL_TIMEOUT = 5,
  parameter logic [3:0]  CMD_READ       = 4'b0110,
  parameter logic [3:0]  CMD_WRITE      = 4'b0111
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [3:0]  req_be,
  input  logic [31:0] wr_data,
  output logic        wr_data_pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic        FRAME,
  output logic        IRDY,
  output logic [3:0]  CBE,
  inout  wire  [31:0] BUS,
  input  logic        TRDY,
  input  logic        DEVSEL
);

  localparam int CW = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ABORT, S_TURN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [3:0]    be_q, be_d;
  logic [3:0]    beats_q, beats_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;
  logic          aborted_q, aborted_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic [3:0]    len_clamped;
  logic          bus_oe;
  logic [31:0]   bus_out;

  assign BUS = bus_oe ? bus_out : 'z;

  always_comb begin
    if (req_len == 4'd0)                 len_clamped = 4'd1;
    else if (int'(req_len) > MAX_BURST)  len_clamped = 4'(MAX_BURST);
    else                                 len_clamped = req_len;
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      be_q       <= '0;
      beats_q    <= '0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      aborted_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      be_q       <= be_d;
      beats_q    <= beats_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      aborted_q  <= aborted_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    be_d       = be_q;
    beats_d    = beats_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    aborted_d  = aborted_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (req) begin
        state_d   = S_ADDR;
        addr_d    = req_addr;
        rw_d      = req_rw;
        be_d      = req_be;
        beats_d   = len_clamped;
        aborted_d = 1'b0;
      end
      S_ADDR: begin
        state_d = S_DATA;
        cnt_d   = '0;
        seen_d  = 1'b0;
      end
      S_DATA: begin
        if (!TRDY) begin
          beats_d = beats_q - 4'd1;
          if (!rw_q) begin
            rd_data_d  = BUS;
            rd_valid_d = 1'b1;
          end
          if (beats_q == 4'd1) state_d = S_TURN;
        end else if (!seen_q && DEVSEL) begin
          // Timeout only applies until some target has claimed the cycle.
          cnt_d = cnt_q + CW'(1);
          if (int'(cnt_q) + 1 >= DEVSEL_TIMEOUT) begin
            state_d   = S_ABORT;
            aborted_d = 1'b1;
          end
        end
        if (!DEVSEL) seen_d = 1'b1;
      end
      S_ABORT: state_d = S_TURN;
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    FRAME       = 1'b1;
    IRDY        = 1'b1;
    CBE         = '0;
    bus_oe      = 1'b0;
    bus_out     = '0;
    done        = 1'b0;
    abort       = 1'b0;
    wr_data_pop = 1'b0;
    busy        = (state_q != S_IDLE);
    unique case (state_q)
      S_ADDR: begin
        FRAME   = 1'b0;
        CBE     = rw_q ? CMD_WRITE : CMD_READ;
        bus_oe  = 1'b1;
        bus_out = addr_q;
      end
      S_DATA: begin
        FRAME       = (beats_q == 4'd1);
        IRDY        = 1'b0;
        CBE         = be_q;
        bus_oe      = rw_q;
        bus_out     = wr_data;
        wr_data_pop = rw_q && !TRDY;
      end
      S_ABORT: begin
        IRDY  = 1'b0;
        CBE   = be_q;
        abort = 1'b1;
      end
      S_TURN:  done = !aborted_q;
      default: ;
    endcase
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_pci_initiator.sv
// Bench for pci_initiator: plays the target side with random claim latency, wait states and data,
// and checks each transaction against the expected beat count, data stream and phase sequence.
module tb_pci_initiator;
  localparam int MAX_BURST = 8;
  localparam int TMO       = 5;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0, req_rw = 1'b0;
  logic [31:0] req_addr = '0, wr_data = '0;
  logic [3:0]  req_len = '0, req_be = '0;
  logic        TRDY = 1'b1, DEVSEL = 1'b1;
  logic        wr_data_pop, rd_valid, busy, done, abort, FRAME, IRDY;
  logic [31:0] rd_data;
  logic [3:0]  CBE;
  logic        tb_oe = 1'b0;
  logic [31:0] tb_bus = '0;
  wire  [31:0] BUS;

  int n_vec = 0;
  int n_err = 0;

  assign BUS = tb_oe ? tb_bus : 'z;

  pci_initiator #(.MAX_BURST(MAX_BURST), .DEVSEL_TIMEOUT(TMO),
                  .CMD_READ(4'b0110), .CMD_WRITE(4'b0111)) dut (
    .CLK(CLK), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_len(req_len), .req_be(req_be), .wr_data(wr_data), .wr_data_pop(wr_data_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .abort(abort),
    .FRAME(FRAME), .IRDY(IRDY), .CBE(CBE), .BUS(BUS), .TRDY(TRDY), .DEVSEL(DEVSEL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_len(input logic [3:0] l);
    if (l == 4'd0) return 1;
    if (int'(l) > MAX_BURST) return MAX_BURST;
    return int'(l);
  endfunction

  // One transaction seen from the target side. lat: data cycles before DEVSEL;
  // wait_beat: force one wait state before that beat; rst_after: reset after that many beats.
  task automatic run_txn(input bit rw, input logic [31:0] addr, input logic [3:0] len,
                         input logic [3:0] be, input int lat, input bit no_tgt,
                         input int wait_beat, input int wait_pct, input int rst_after,
                         input bit noise);
    int n, beat, dcyc, pops, guard;
    bit dev_lo, trdy_lo, prev_rd, waited;
    logic [31:0] exp_rd, word;
    n = clamp_len(len);
    beat = 0; dcyc = 0; pops = 0; guard = 0;
    prev_rd = 1'b0; waited = 1'b0; exp_rd = '0;

    @(negedge CLK);
    req = 1'b1; req_rw = rw; req_addr = addr; req_len = len; req_be = be;
    TRDY = 1'b1; DEVSEL = 1'b1; tb_oe = 1'b0;
    @(negedge CLK);
    // Scramble request inputs so only the latched copies can be in use.
    req = noise; req_rw = ~rw; req_addr = $urandom; req_len = 4'($urandom); req_be = 4'($urandom);
    #1;
    check("addr_busy",  busy, 1);
    check("addr_frame", FRAME, 0);
    check("addr_irdy",  IRDY, 1);
    check("addr_cbe",   CBE, rw ? 4'b0111 : 4'b0110);
    check("addr_oe",    dut.bus_oe, 1);
    check("addr_bus",   BUS, addr);

    while (beat < n && guard < 200) begin
      @(negedge CLK);
      guard++;
      if (noise) req = 1'($urandom_range(0, 1));
      dev_lo  = !no_tgt && dcyc >= lat;
      trdy_lo = dev_lo;
      if (dev_lo && beat == wait_beat && !waited) begin
        trdy_lo = 1'b0;
        waited  = 1'b1;
      end else if (dev_lo && $urandom_range(0, 99) < wait_pct) begin
        trdy_lo = 1'b0;
      end
      DEVSEL = !dev_lo;
      TRDY   = !trdy_lo;
      word   = $urandom;
      if (rw) begin
        wr_data = word; tb_oe = 1'b0;
      end else begin
        tb_bus = word; tb_oe = trdy_lo;
      end
      #1;
      check("data_rdv", rd_valid, prev_rd);
      if (prev_rd) check("data_rdd", rd_data, exp_rd);
      check("data_irdy",  IRDY, 0);
      check("data_cbe",   CBE, be);
      check("data_frame", FRAME, (beat == n - 1));
      check("data_pop",   wr_data_pop, rw && trdy_lo);
      check("data_oe",    dut.bus_oe, rw);
      if (rw) check("data_bus", BUS, word);
      check("data_done",  done, 0);
      if (wr_data_pop) pops++;
      prev_rd = 1'b0;
      if (trdy_lo) begin
        beat++;
        if (!rw) begin prev_rd = 1'b1; exp_rd = word; end
      end
      dcyc++;
      if (no_tgt && dcyc == TMO) break;
      if (rst_after > 0 && beat == rst_after) break;
    end
    if (guard >= 200) check("beat_budget", guard, 0);

    if (rst_after > 0) begin
      check("rst_pops", pops, rst_after);
      @(negedge CLK);
      TRDY = 1'b1; DEVSEL = 1'b1; tb_oe = 1'b0; req = 1'b0; reset = 1'b0;
      @(negedge CLK);
      #1;
      check("rst_frame", FRAME, 1);
      check("rst_irdy",  IRDY, 1);
      check("rst_cbe",   CBE, 0);
      check("rst_oe",    dut.bus_oe, 0);
      check("rst_busy",  busy, 0);
      check("rst_done",  done, 0);
      check("rst_abort", abort, 0);
      reset = 1'b1;
      return;
    end

    @(negedge CLK);
    TRDY = 1'b1; DEVSEL = 1'b1; tb_oe = 1'b0;
    #1;
    if (no_tgt) begin
      check("abt_abort", abort, 1);
      check("abt_frame", FRAME, 1);
      check("abt_irdy",  IRDY, 0);
      check("abt_oe",    dut.bus_oe, 0);
      check("abt_done",  done, 0);
      check("abt_rdv",   rd_valid, 0);
      check("abt_pops",  pops, 0);
      @(negedge CLK);
      #1;
      check("aturn_frame", FRAME, 1);
      check("aturn_irdy",  IRDY, 1);
      check("aturn_done",  done, 0);
      check("aturn_abort", abort, 0);
    end else begin
      check("turn_done",  done, 1);
      check("turn_frame", FRAME, 1);
      check("turn_irdy",  IRDY, 1);
      check("turn_cbe",   CBE, 0);
      check("turn_oe",    dut.bus_oe, 0);
      check("turn_abort", abort, 0);
      check("turn_pop",   wr_data_pop, 0);
      check("turn_rdv",   rd_valid, prev_rd);
      if (prev_rd) check("turn_rdd", rd_data, exp_rd);
      check("pops", pops, rw ? n : 0);
    end
    @(negedge CLK);
    req = 1'b0;
    #1;
    check("idle_busy",  busy, 0);
    check("idle_done",  done, 0);
    check("idle_abort", abort, 0);
    check("idle_frame", FRAME, 1);
    check("idle_rdv",   rd_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    check("reset_frame", FRAME, 1);
    check("reset_irdy",  IRDY, 1);
    check("reset_cbe",   CBE, 0);
    check("reset_oe",    dut.bus_oe, 0);
    check("reset_busy",  busy, 0);
    check("reset_done",  done, 0);
    check("reset_abort", abort, 0);
    check("reset_rdv",   rd_valid, 0);
    check("reset_pop",   wr_data_pop, 0);
    check("reset_rdd",   rd_data, 0);
    reset = 1'b1;

    run_txn(1'b1, 32'h1111_1112, 4'd1,  4'hF, 2, 1'b0, -1, 0, 0, 1'b0);
    run_txn(1'b0, 32'h1111_1110, 4'd4,  4'hF, 0, 1'b0,  1, 0, 0, 1'b0);
    run_txn(1'b0, 32'h2222_2220, 4'd2,  4'h3, 0, 1'b1, -1, 0, 0, 1'b0);
    run_txn(1'b1, 32'h3333_3330, 4'd8,  4'hF, 1, 1'b0, -1, 0, 3, 1'b0);
    run_txn(1'b1, 32'h4444_4440, 4'd0,  4'h5, 0, 1'b0, -1, 0, 0, 1'b0);
    run_txn(1'b1, 32'h5555_5550, 4'd12, 4'hA, 0, 1'b0, -1, 0, 0, 1'b0);
    run_txn(1'b1, 32'h6666_6660, 4'd3,  4'hF, 1, 1'b0, -1, 20, 0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              4'($urandom), $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
              -1, 30, 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
